axi_bram_burst_writer: RTL and testbench
========================================

// Module: axi_bram_burst_writer
// PURPOSE
//  AXI4 (full) write-only slave that turns INCR/FIXED write bursts into BRAM port-A byte-enabled writes.
//  Successor to the single-beat AXI4-Lite BRAM writer; adds bursts, independent AW/W handshakes, IDs and error response.
//  Sits between the PS/interconnect master port and a simple-dual-port BRAM (coefficient/waveform tables).
// PARAMETERS
//  AXI_DATA_WIDTH  32  AXI and BRAM data width in bits (8,16,32,64,...; BRAM_DATA_WIDTH == AXI_DATA_WIDTH)
//  AXI_ADDR_WIDTH  32  AXI byte-address width
//  AXI_ID_WIDTH    6   AWID/BID width
//  BRAM_ADDR_WIDTH 10  BRAM word-address width; depth = 2**BRAM_ADDR_WIDTH
// PORTS
//  aclk               in   1                  clock; BRAM clock = aclk
//  areset             in   1                  synchronous, active-high reset
//  s_axi_awid         in   AXI_ID_WIDTH       write ID
//  s_axi_awaddr       in   AXI_ADDR_WIDTH     burst start byte address
//  s_axi_awlen        in   8                  beats-1
//  s_axi_awsize       in   3                  ignored; full-width beats required
//  s_axi_awburst      in   2                  00 FIXED, 01 INCR, 10 WRAP
//  s_axi_awvalid      in   1                  / s_axi_awready out 1
//  s_axi_wdata        in   AXI_DATA_WIDTH     / s_axi_wstrb in AXI_DATA_WIDTH/8
//  s_axi_wlast        in   1                  / s_axi_wvalid in 1 / s_axi_wready out 1
//  s_axi_bid          out  AXI_ID_WIDTH       / s_axi_bresp out 2 / s_axi_bvalid out 1 / s_axi_bready in 1
//  bram_porta_clk     out  1                  = aclk
//  bram_porta_rst     out  1                  = areset
//  bram_porta_addr    out  BRAM_ADDR_WIDTH    registered word address
//  bram_porta_wrdata  out  AXI_DATA_WIDTH     registered write data
//  bram_porta_we      out  AXI_DATA_WIDTH/8   registered byte enables
// BEHAVIOUR
//  Reset: state IDLE; awready=1, wready=0, bvalid=0, bresp=0, bid=0, bram addr/wrdata=0, we=0.
//  FSM IDLE -> BURST on AW handshake (awvalid&awready): latch id, word addr = awaddr[ADDR_LSB+:BRAM_ADDR_WIDTH]
//   (ADDR_LSB=log2(AXI_DATA_WIDTH/8)), len, burst; clear beat counter and err flag; awready<=0, wready<=1.
//  BURST: each W handshake -> next cycle bram addr=current word addr, wrdata=wdata, we=wstrb (1-cycle latency);
//   we=0 on every cycle without a W handshake. INCR/WRAP: addr+1 mod 2**BRAM_ADDR_WIDTH (wraps silently, no error).
//   FIXED: addr held. Beat counter counts 0..len.
//  Burst ends after exactly len+1 beats regardless of wlast; wready<=0 in same cycle as final handshake; -> RESP.
//  Error flag (sticky per burst): wlast=1 on a non-final beat, wlast=0 on final beat, or awburst==WRAP
//   (WRAP executes as INCR). Data is still written on error.
//  RESP: bvalid=1, bid=latched id, bresp = err ? SLVERR(2'b10) : OKAY(2'b00); bvalid rises the cycle after final
//   W handshake (same cycle the final BRAM write is presented). Hold until bready; on bvalid&bready -> IDLE,
//   bvalid<=0, awready<=1. No AW accepted before B completes (one outstanding burst).
//  W before AW: wready=0 in IDLE, so W beats stall; AW and W in same cycle -> AW taken, W taken next cycle.
//  bready held low: FSM stays in RESP indefinitely, no AW/W accepted.
//  Reset mid-burst: abandon burst, no B response, we=0 the cycle after areset sampled, all outputs to reset values.
//  Throughput: 1 beat/cycle in BURST; overhead 1 cycle AW + 1 cycle min B per burst.
// STRUCTURE
//  Package axi_bram_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/RESP_SLVERR localparams, state encoding
//   (IDLE/BURST/RESP). Single module; no sub-module (address/beat counter is inline, too small to split).
//  ADDR_LSB computed with clogb2 function local to the module.
// TESTING
//  1) AW addr 0x10 len 0 INCR, W 0xDEADBEEF strb 0xF wlast=1 -> one write addr 4 we 0xF; B OKAY, bid echoed.
//  2) AW addr 0x0 len 3 INCR, 4 back-to-back beats, strb 0x3 -> addrs 0,1,2,3 consecutive cycles, we=0x3; OKAY.
//  3) AW addr 0xFF8 len 3 INCR (BRAM_ADDR_WIDTH=10) -> addrs 1022,1023,0,1; OKAY. FIXED len 2 at 0x20 -> addr 8 x3.
//  4) len 3 with wlast on beat 1 -> 4 writes still issued, bresp=SLVERR; awburst=WRAP -> INCR writes, SLVERR.
//  5) W valid 3 cycles before AW, random wvalid gaps, bready low 5 cycles -> no write before AW, we only on
//   handshakes, bvalid stable until bready, next AW blocked until B done.
//  6) areset asserted after beat 1 of a len 7 burst -> we=0 next cycle, no bvalid, awready=1; new burst completes OKAY.

Source files
------------

// File: rtl/axi_bram_pkg.sv
// Shared encodings for the AXI4 burst-to-BRAM write path.
package axi_bram_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RESP} state_t;
endpackage

// File: rtl/axi_bram_burst_writer.sv
// AXI4 write-only slave: one outstanding INCR/FIXED burst, beats written to BRAM port A
// with one cycle of registered latency. WRAP runs as INCR and is flagged SLVERR.
module axi_bram_burst_writer
  import axi_bram_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 6,
  parameter int BRAM_ADDR_WIDTH = 10
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic                          bram_porta_clk,
  output logic                          bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]    bram_porta_addr,
  output logic [AXI_DATA_WIDTH-1:0]     bram_porta_wrdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   bram_porta_we
);
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int ADDR_LSB = clogb2(AXI_DATA_WIDTH/8);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                       state, state_nxt;
  logic [AXI_ID_WIDTH-1:0]      id_q;
  logic [BRAM_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                   len_q;
  logic [7:0]                   beat_q;
  logic [1:0]                   burst_q;
  logic                         err_q;
  logic                         aw_hs, w_hs, last_beat, b_hs;
  logic                         unused;

  assign unused = ^{s_axi_awsize, s_axi_awaddr};

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign b_hs      = s_axi_bvalid & s_axi_bready;
  assign last_beat = (beat_q == len_q);

  assign bram_porta_clk = aclk;
  assign bram_porta_rst = areset;

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (aw_hs)             state_nxt = ST_BURST;
      ST_BURST: if (w_hs && last_beat) state_nxt = ST_RESP;
      ST_RESP:  if (b_hs)              state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (state == ST_IDLE);
    s_axi_wready  = (state == ST_BURST);
    s_axi_bvalid  = (state == ST_RESP);
    s_axi_bid     = id_q;
    s_axi_bresp   = (state == ST_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
  end

  // Burst bookkeeping and the registered BRAM port; we is a one-cycle pulse per beat.
  always_ff @(posedge aclk) begin
    if (areset) begin
      id_q              <= '0;
      addr_q            <= '0;
      len_q             <= '0;
      beat_q            <= '0;
      burst_q           <= BURST_FIXED;
      err_q             <= 1'b0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
      bram_porta_we     <= '0;
    end else begin
      bram_porta_we <= '0;
      if (aw_hs) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr[ADDR_LSB +: BRAM_ADDR_WIDTH];
        len_q   <= s_axi_awlen;
        burst_q <= s_axi_awburst;
        beat_q  <= '0;
        err_q   <= (s_axi_awburst == BURST_WRAP);
      end
      if (w_hs) begin
        bram_porta_addr   <= addr_q;
        bram_porta_wrdata <= s_axi_wdata;
        bram_porta_we     <= s_axi_wstrb;
        beat_q            <= beat_q + 8'd1;
        if (burst_q != BURST_FIXED) addr_q <= addr_q + ADDR_ONE;
        if (s_axi_wlast != last_beat) err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_bram_burst_writer.sv
// Randomized bench: a per-beat write list and a response model are derived from the burst
// parameters and compared against the BRAM port and B channel.
module tb_axi_bram_burst_writer;
  import axi_bram_pkg::*;
  localparam int DW = 32, AW = 32, IW = 6, BAW = 10, SW = DW/8;

  logic aclk = 1'b0, areset;
  logic [IW-1:0]  s_axi_awid;
  logic [AW-1:0]  s_axi_awaddr;
  logic [7:0]     s_axi_awlen;
  logic [2:0]     s_axi_awsize;
  logic [1:0]     s_axi_awburst;
  logic           s_axi_awvalid, s_axi_awready;
  logic [DW-1:0]  s_axi_wdata;
  logic [SW-1:0]  s_axi_wstrb;
  logic           s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [IW-1:0]  s_axi_bid;
  logic [1:0]     s_axi_bresp;
  logic           s_axi_bvalid, s_axi_bready;
  logic           bram_porta_clk, bram_porta_rst;
  logic [BAW-1:0] bram_porta_addr;
  logic [DW-1:0]  bram_porta_wrdata;
  logic [SW-1:0]  bram_porta_we;

  always #5 aclk = ~aclk;

  axi_bram_burst_writer #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW),
                          .BRAM_ADDR_WIDTH(BAW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .bram_porta_clk(bram_porta_clk), .bram_porta_rst(bram_porta_rst),
    .bram_porta_addr(bram_porta_addr), .bram_porta_wrdata(bram_porta_wrdata),
    .bram_porta_we(bram_porta_we)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { logic [BAW-1:0] addr; logic [DW-1:0] data; logic [SW-1:0] strb; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  // Every enabled BRAM write must match the oldest outstanding accepted beat.
  always @(negedge aclk) begin
    if (bram_porta_we != '0) begin
      if (exp_q.size() == 0) chk("spurious_we", 64'(bram_porta_we), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bram_porta_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(bram_porta_wrdata), 64'(mon_e.data));
        chk("wr_we", 64'(bram_porta_we), 64'(mon_e.strb));
      end
    end
  end

  function automatic logic wlast_for(input int b, input int len, input int bad);
    return (b == len) ^ (b == bad);
  endfunction

  task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                           input logic [1:0] bt, input int bad_beat, input logic [SW-1:0] strb_fix,
                           input int gap_pct, input int bwait, input bit w_early, input int abort_after);
    logic [BAW-1:0] start;
    logic [DW-1:0]  d[$];
    logic [SW-1:0]  s[$];
    logic [1:0]     exp_resp;
    wr_t            e;
    bit             err, hs;
    int             beat, n;
    start = addr[2 +: BAW];
    err = (bt == BURST_WRAP) || (bad_beat >= 0 && bad_beat <= len);
    exp_resp = err ? RESP_SLVERR : RESP_OKAY;
    for (int i = 0; i <= len; i++) begin
      d.push_back($urandom);
      s.push_back(strb_fix != '0 ? strb_fix : SW'($urandom_range(1, (1 << SW) - 1)));
    end

    @(negedge aclk);
    if (w_early) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = d[0]; s_axi_wstrb = s[0];
      s_axi_wlast = wlast_for(0, len, bad_beat);
      repeat (3) begin
        chk("w_early_wready", 64'(s_axi_wready), 64'd0);
        @(negedge aclk);
      end
    end
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awburst = bt;
    s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    chk("aw_ready", 64'(s_axi_awready), 64'd1);
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    chk("aw_closed", 64'(s_axi_awready), 64'd0);

    beat = 0; n = 0;
    while (beat <= len && n < 2000) begin
      if (abort_after >= 0 && beat == abort_after + 1) break;
      if (!(w_early && n == 0) && $urandom_range(0, 99) < gap_pct) s_axi_wvalid = 1'b0;
      else begin
        s_axi_wvalid = 1'b1; s_axi_wdata = d[beat]; s_axi_wstrb = s[beat];
        s_axi_wlast = wlast_for(beat, len, bad_beat);
      end
      chk("w_ready", 64'(s_axi_wready), 64'd1);
      chk("aw_blocked", 64'(s_axi_awready), 64'd0);
      hs = s_axi_wvalid && s_axi_wready;
      if (hs) begin
        e.addr = (bt == BURST_FIXED) ? start : BAW'(start + beat);
        e.data = d[beat]; e.strb = s[beat];
        exp_q.push_back(e);
      end
      @(negedge aclk);
      n++;
      if (hs) beat++;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

    if (abort_after >= 0) begin
      areset = 1'b1;
      @(negedge aclk);
      chk("rst_we", 64'(bram_porta_we), 64'd0);
      chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
      chk("rst_awready", 64'(s_axi_awready), 64'd1);
      chk("rst_wready", 64'(s_axi_wready), 64'd0);
      chk("rst_addr", 64'(bram_porta_addr), 64'd0);
      chk("rst_bram_rst", 64'(bram_porta_rst), 64'd1);
      areset = 1'b0;
      chk("rst_pending_writes", 64'(exp_q.size()), 64'd0);
      return;
    end

    chk("beats_done", 64'(beat), 64'(len + 1));
    chk("b_timing", 64'(s_axi_bvalid), 64'd1);
    chk("w_closed", 64'(s_axi_wready), 64'd0);
    chk("bid", 64'(s_axi_bid), 64'(id));
    chk("bresp", 64'(s_axi_bresp), 64'(exp_resp));
    repeat (bwait) begin
      @(negedge aclk);
      chk("b_hold", 64'(s_axi_bvalid), 64'd1);
      chk("b_hold_resp", 64'(s_axi_bresp), 64'(exp_resp));
      chk("resp_aw_blocked", 64'(s_axi_awready), 64'd0);
      chk("resp_w_blocked", 64'(s_axi_wready), 64'd0);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    s_axi_bready = 1'b0;
    chk("b_done", 64'(s_axi_bvalid), 64'd0);
    chk("aw_reopen", 64'(s_axi_awready), 64'd1);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int len, bad;
    areset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_awready", 64'(s_axi_awready), 64'd1);
    chk("reset_wready", 64'(s_axi_wready), 64'd0);
    chk("reset_bvalid", 64'(s_axi_bvalid), 64'd0);
    chk("reset_bresp", 64'(s_axi_bresp), 64'd0);
    chk("reset_bid", 64'(s_axi_bid), 64'd0);
    chk("reset_addr", 64'(bram_porta_addr), 64'd0);
    chk("reset_wrdata", 64'(bram_porta_wrdata), 64'd0);
    chk("reset_we", 64'(bram_porta_we), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    run_burst(6'h05, 32'h10,  0, BURST_INCR,  -1, 4'hF, 0,  0, 1'b0, -1);
    run_burst(6'h11, 32'h0,   3, BURST_INCR,  -1, 4'h3, 0,  0, 1'b0, -1);
    run_burst(6'h22, 32'hFF8, 3, BURST_INCR,  -1, 4'h0, 0,  1, 1'b0, -1);
    run_burst(6'h23, 32'h20,  2, BURST_FIXED, -1, 4'h0, 0,  0, 1'b0, -1);
    run_burst(6'h31, 32'h40,  3, BURST_INCR,   1, 4'h0, 0,  0, 1'b0, -1);
    run_burst(6'h32, 32'h80,  3, BURST_WRAP,  -1, 4'h0, 0,  0, 1'b0, -1);
    run_burst(6'h33, 32'hC0,  2, BURST_INCR,   2, 4'h0, 0,  0, 1'b0, -1);
    run_burst(6'h15, 32'h100, 5, BURST_INCR,  -1, 4'h0, 40, 5, 1'b1, -1);
    run_burst(6'h3E, 32'h200, 7, BURST_INCR,  -1, 4'h0, 0,  0, 1'b0,  1);
    run_burst(6'h3F, 32'h300, 3, BURST_INCR,  -1, 4'h0, 0,  0, 1'b0, -1);

    for (int k = 0; k < 25; k++) begin
      len = $urandom_range(0, 15);
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      run_burst(IW'($urandom), $urandom, len, 2'($urandom_range(0, 2)), bad, '0,
                $urandom_range(0, 50), $urandom_range(0, 3), 1'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
